// File: rtl/snes_pkg.sv
// ---------------------------------------------------------------------------
// snes_pkg
// Shared definitions for the SNES joypad serial path.
//   SNES_BITS       : length of one serial frame
//   SNES_B..SNES_R  : bit position of each button inside the frame
//   SNES_ID_NIBBLE  : level driven on the four trailing ID bits
//   snes_state_t    : responder state encoding
//   snes_image()    : builds the active-low frame image from pressed buttons
// ---------------------------------------------------------------------------
package snes_pkg;

  localparam int SNES_BITS = 16;

  localparam int SNES_B      = 0;
  localparam int SNES_Y      = 1;
  localparam int SNES_SELECT = 2;
  localparam int SNES_START  = 3;
  localparam int SNES_UP     = 4;
  localparam int SNES_DOWN   = 5;
  localparam int SNES_LEFT   = 6;
  localparam int SNES_RIGHT  = 7;
  localparam int SNES_A      = 8;
  localparam int SNES_X      = 9;
  localparam int SNES_L      = 10;
  localparam int SNES_R      = 11;

  localparam logic [3:0] SNES_ID_NIBBLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } snes_state_t;

  // The line is active-low: a pressed button (1) is sent as 0, and the
  // four ID bits are held high so the host recognises a standard pad.
  function automatic logic [SNES_BITS-1:0] snes_image(input logic [SNES_R:SNES_B] buttons);
    return {SNES_ID_NIBBLE, ~buttons};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Multi-flop synchronizer for an asynchronous pin, with registered
// one-cycle rise/fall pulses derived from the synchronized level.
//   clock    in  : core clock
//   reset    in  : synchronous, active-high
//   async_in in  : asynchronous pin
//   level    out : synchronized level (STAGES cycles behind the pin)
//   rise     out : one-cycle pulse, one cycle after level goes 0->1
//   fall     out : one-cycle pulse, one cycle after level goes 1->0
// ---------------------------------------------------------------------------
module sync_edge #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Synchronizer chain plus a delayed copy of its output; the edge pulses
  // are registered so downstream logic sees clean single-cycle strobes.
  // Resetting everything to RESET_VALUE keeps a pin that idles at that
  // level from producing a spurious edge when reset is released.
  always_ff @(posedge clock) begin
    if (reset) begin
      chain <= {STAGES{RESET_VALUE}};
      prev  <= RESET_VALUE;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~prev;
      fall  <= ~chain[STAGES-1] & prev;
    end
  end

  assign level = chain[STAGES-1];

endmodule

// File: rtl/snes_pad_responder.sv
// ---------------------------------------------------------------------------
// snes_pad_responder
// Controller-side end of the SNES joypad protocol: answers the host's
// latch/clock pins with a 16-bit active-low button frame on pad_data.
//   clock        in  : core clock (33.33 MHz)
//   reset        in  : synchronous, active-high
//   button_state in  : pressed = 1, [11:0] buttons, [15:12] ignored
//   pad_latch    in  : host latch pin, asynchronous, active-high
//   pad_clock    in  : host clock pin, asynchronous, idles high
//   pad_data     out : registered serial data, active-low
//   frame_start  out : one-cycle pulse when the latch is released
//   frame_done   out : one-cycle pulse on the 16th shift
//   bit_count    out : shifts since last latch, saturates at 16
// ---------------------------------------------------------------------------
module snes_pad_responder
  import snes_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic FILL_BIT    = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] button_state,
  input  logic        pad_latch,
  input  logic        pad_clock,
  output logic        pad_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic [4:0]  bit_count
);

  snes_state_t          state;
  logic [SNES_BITS-1:0] shift_reg;
  logic [SNES_BITS-1:0] img;

  logic latch_level;
  logic latch_fall;
  logic clock_rise;
  logic unused_latch_rise;
  logic unused_clock_level;
  logic unused_clock_fall;
  logic unused_id_buttons;

  assign img               = snes_image(button_state[SNES_R:SNES_B]);
  assign unused_id_buttons = ^button_state[15:12];

  sync_edge #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (1'b0)
  ) u_latch_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (pad_latch),
    .level    (latch_level),
    .rise     (unused_latch_rise),
    .fall     (latch_fall)
  );

  sync_edge #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (1'b1)
  ) u_clock_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (pad_clock),
    .level    (unused_clock_level),
    .rise     (clock_rise),
    .fall     (unused_clock_fall)
  );

  // Responder FSM with shift register, counter and registered outputs.
  // A high latch overrides everything, so a clock edge arriving together
  // with it is simply dropped. While latched the image is reloaded every
  // cycle so the first bit follows the switches live; once shifting starts
  // the buttons are no longer looked at, which freezes the frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      shift_reg   <= '1;
      pad_data    <= 1'b1;
      bit_count   <= 5'd0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (latch_level) begin
        state     <= ST_LOAD;
        shift_reg <= img;
        bit_count <= 5'd0;
        pad_data  <= img[0];
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_IDLE;
          end
          ST_LOAD: begin
            shift_reg <= img;
            bit_count <= 5'd0;
            pad_data  <= img[0];
            if (latch_fall) begin
              state       <= ST_SHIFT;
              frame_start <= 1'b1;
            end
          end
          ST_SHIFT: begin
            if (clock_rise) begin
              shift_reg <= {FILL_BIT, shift_reg[SNES_BITS-1:1]};
              pad_data  <= shift_reg[1];
              bit_count <= bit_count + 5'd1;
              if (bit_count == 5'd15) begin
                frame_done <= 1'b1;
                state      <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            if (clock_rise) begin
              shift_reg <= {FILL_BIT, shift_reg[SNES_BITS-1:1]};
              pad_data  <= FILL_BIT;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
